// File: rtl/usb4_clk_pkg.sv
// Shared types and constants for the USB4 clock speed-switch controller.
// Holds the sequencer state encoding, gen_speed encodings and default cycle counts.
package usb4_clk_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_DRAIN,
        ST_HOLD,
        ST_SETTLE,
        ST_DONE
    } sw_state_t;

    localparam logic [1:0] GEN_SPD_0   = 2'b00;
    localparam logic [1:0] GEN_SPD_1   = 2'b01;
    localparam logic [1:0] GEN_SPD_2   = 2'b10;
    localparam logic [1:0] GEN_SPD_INV = 2'b11;

    localparam int DEF_DRAIN_MIN      = 8;
    localparam int DEF_RST_CYCLES     = 4;
    localparam int DEF_SETTLE_CYCLES  = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/sw_wait_timer.sv
// 8-bit wait timer shared by the INIT, DRAIN, HOLD and SETTLE states.
// i_load restarts the count at 0; o_expired is high once i_limit cycles have elapsed.
module sw_wait_timer (
    input  logic       local_clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_limit,
    output logic       o_expired
);

    logic [7:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Counting starts at 0 in a state's first cycle, so expiry is at limit-1.
    assign o_expired = (r_cnt >= (i_limit - 8'd1));

endmodule

// File: rtl/speed_switch_ctrl.sv
// Sequences a gen_speed change: drain, divider reset hold, settle, re-enable.
// Optional drain watchdog is compiled in with SPEED_SW_TIMEOUT_EN.
module speed_switch_ctrl
    import usb4_clk_pkg::*;
#(
    parameter int DRAIN_MIN      = DEF_DRAIN_MIN,
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       local_clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_speed,
    output logic       req_ready,
    input  logic       drain_ack,
    output logic [1:0] gen_speed,
    output logic       div_rst_n,
    output logic       clk_gate_en,
    output logic       busy,
    output logic       switch_done,
    output logic       switch_err
);

    localparam logic [7:0] L_DRAIN  = 8'(DRAIN_MIN);
    localparam logic [7:0] L_RST    = 8'(RST_CYCLES);
    localparam logic [7:0] L_SETTLE = 8'(SETTLE_CYCLES);

    sw_state_t  r_state;
    sw_state_t  w_next;
    logic [1:0] r_req_speed;
    logic [1:0] r_gen_speed;
    logic       r_ack_seen;
    logic       r_switch_done;
    logic       r_switch_err;
    logic       w_done_set;
    logic       w_err_set;
    logic       w_latch;
    logic       w_load;
    logic       w_expired;
    logic       w_drain_exit;
    logic       w_wd_expired;
    logic [7:0] w_limit;

    always_comb begin
        w_limit = L_RST;
        case (r_state)
            ST_DRAIN:  w_limit = L_DRAIN;
            ST_SETTLE: w_limit = L_SETTLE;
            default:   w_limit = L_RST;
        endcase
    end

    sw_wait_timer u_timer (
        .local_clk (local_clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_limit   (w_limit),
        .o_expired (w_expired)
    );

    assign w_drain_exit = w_expired && (r_ack_seen || drain_ack);

`ifdef SPEED_SW_TIMEOUT_EN
    logic [15:0] r_wd;

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            r_wd <= '0;
        end else if (w_load) begin
            r_wd <= '0;
        end else if (r_state == ST_DRAIN && r_wd != 16'hFFFF) begin
            r_wd <= r_wd + 16'd1;
        end
    end

    assign w_wd_expired = (r_state == ST_DRAIN) && (r_wd == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_wd_expired = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next     = r_state;
        w_done_set = 1'b0;
        w_err_set  = 1'b0;
        w_latch    = 1'b0;
        case (r_state)
            ST_INIT:   if (w_expired) w_next = ST_SETTLE;
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_speed == GEN_SPD_INV) begin
                        w_err_set = 1'b1;
                    end else if (req_speed == r_gen_speed) begin
                        w_done_set = 1'b1;
                    end else begin
                        w_latch = 1'b1;
                        w_next  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_drain_exit) begin
                    w_next = ST_HOLD;
                end else if (w_wd_expired) begin
                    w_next    = ST_IDLE;
                    w_err_set = 1'b1;
                end
            end
            ST_HOLD:   if (w_expired) w_next = ST_SETTLE;
            ST_SETTLE: if (w_expired) w_next = ST_DONE;
            ST_DONE: begin
                w_next     = ST_IDLE;
                w_done_set = 1'b1;
            end
            default:   w_next = ST_INIT;
        endcase
    end

    assign w_load = (w_next != r_state);

    // NOTE: async active-low reset returns to INIT and drops any latched request.
    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_INIT;
            r_req_speed   <= GEN_SPD_0;
            r_gen_speed   <= GEN_SPD_0;
            r_ack_seen    <= 1'b0;
            r_switch_done <= 1'b0;
            r_switch_err  <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_switch_done <= w_done_set;
            r_switch_err  <= w_err_set;
            if (w_latch) begin
                r_req_speed <= req_speed;
            end
            if (w_latch) begin
                r_ack_seen <= 1'b0;
            end else if (r_state == ST_DRAIN && drain_ack) begin
                r_ack_seen <= 1'b1;
            end
            // The divider ratio moves only as the divider enters reset.
            if (r_state == ST_DRAIN && w_next == ST_HOLD) begin
                r_gen_speed <= r_req_speed;
            end
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign div_rst_n   = !(r_state == ST_INIT || r_state == ST_HOLD);
    assign clk_gate_en = (r_state == ST_IDLE || r_state == ST_DONE);
    assign gen_speed   = r_gen_speed;
    assign switch_done = r_switch_done;
    assign switch_err  = r_switch_err;

endmodule

// File: tb/tb_speed_switch_ctrl.sv
// Directed bench for speed_switch_ctrl: reset, switches, rejects, mid-sequence reset.
// The watchdog section follows SPEED_SW_TIMEOUT_EN.
module tb_speed_switch_ctrl;

    logic       local_clk = 1'b0;
    logic       rst       = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_speed = 2'b00;
    logic       drain_ack = 1'b0;
    logic       req_ready;
    logic [1:0] gen_speed;
    logic       div_rst_n;
    logic       clk_gate_en;
    logic       busy;
    logic       switch_done;
    logic       switch_err;

    int errors = 0;
    int checks = 0;
    int n_done;
    int first_done;

    always #5 local_clk = ~local_clk;

    speed_switch_ctrl #(
        .DRAIN_MIN      (8),
        .RST_CYCLES     (4),
        .SETTLE_CYCLES  (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .local_clk   (local_clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_speed   (req_speed),
        .req_ready   (req_ready),
        .drain_ack   (drain_ack),
        .gen_speed   (gen_speed),
        .div_rst_n   (div_rst_n),
        .clk_gate_en (clk_gate_en),
        .busy        (busy),
        .switch_done (switch_done),
        .switch_err  (switch_err)
    );

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge local_clk);
        @(negedge local_clk);
    endtask

    task automatic check_reset_vals(input string ctx);
        check({ctx, ".gen_speed"},   int'(gen_speed),   0);
        check({ctx, ".div_rst_n"},   int'(div_rst_n),   0);
        check({ctx, ".clk_gate_en"}, int'(clk_gate_en), 0);
        check({ctx, ".req_ready"},   int'(req_ready),   0);
        check({ctx, ".busy"},        int'(busy),        1);
        check({ctx, ".switch_done"}, int'(switch_done), 0);
        check({ctx, ".switch_err"},  int'(switch_err),  0);
    endtask

    // Caller releases rst at a negedge (cycle 1); ends in cycle 22 (first IDLE cycle).
    task automatic check_init_seq(input string ctx);
        check({ctx, ".c1_div"},   int'(div_rst_n), 0);
        wait_cyc(3);
        check({ctx, ".c4_div"},   int'(div_rst_n), 0);
        wait_cyc(1);
        check({ctx, ".c5_div"},   int'(div_rst_n), 1);
        check({ctx, ".c5_gate"},  int'(clk_gate_en), 0);
        wait_cyc(16);
        check({ctx, ".c21_rdy"},  int'(req_ready), 0);
        check({ctx, ".c21_busy"}, int'(busy), 1);
        wait_cyc(1);
        check({ctx, ".c22_rdy"},  int'(req_ready), 1);
        check({ctx, ".c22_gate"}, int'(clk_gate_en), 1);
        check({ctx, ".c22_gen"},  int'(gen_speed), 0);
        check({ctx, ".c22_done"}, int'(switch_done), 1);
    endtask

    initial begin
        // Power-on reset
        @(negedge local_clk);
        check_reset_vals("por");
        rst = 1'b1;
        check_init_seq("init");
        wait_cyc(1);
        check("init.c23_done", int'(switch_done), 0);

        // Switch to 01, drain_ack rising at cycle 40; an 11 request during DRAIN is ignored
        req_valid = 1'b1; req_speed = 2'b01; drain_ack = 1'b0;
        wait_cyc(1);
        check("sw01.c1_gate", int'(clk_gate_en), 0);
        check("sw01.c1_busy", int'(busy), 1);
        check("sw01.c1_rdy",  int'(req_ready), 0);
        req_speed = 2'b11;
        wait_cyc(1);
        check("sw01.ignored_err", int'(switch_err), 0);
        req_valid = 1'b0;
        wait_cyc(18);
        check("sw01.c20_gen", int'(gen_speed), 0);
        check("sw01.c20_div", int'(div_rst_n), 1);
        wait_cyc(20);
        check("sw01.c40_gen",  int'(gen_speed), 0);
        check("sw01.c40_busy", int'(busy), 1);
        drain_ack = 1'b1;
        wait_cyc(1);
        check("sw01.c41_gen", int'(gen_speed), 1);
        check("sw01.c41_div", int'(div_rst_n), 0);
        drain_ack = 1'b0;
        wait_cyc(20);
        check("sw01.c61_gate", int'(clk_gate_en), 1);
        check("sw01.c61_done", int'(switch_done), 0);
        wait_cyc(1);
        check("sw01.c62_done", int'(switch_done), 1);
        check("sw01.c62_rdy",  int'(req_ready), 1);

        // Switch to 10 with drain_ack held high
        req_valid = 1'b1; req_speed = 2'b10; drain_ack = 1'b1;
        wait_cyc(1);
        req_valid = 1'b0;
        check("sw10.c1_gate", int'(clk_gate_en), 0);
        check("sw10.c1_gen",  int'(gen_speed), 1);
        wait_cyc(7);
        check("sw10.c8_gen", int'(gen_speed), 1);
        check("sw10.c8_div", int'(div_rst_n), 1);
        wait_cyc(1);
        check("sw10.c9_gen", int'(gen_speed), 2);
        check("sw10.c9_div", int'(div_rst_n), 0);
        drain_ack  = 1'b0;
        n_done     = 0;
        first_done = 0;
        for (int c = 10; c <= 35; c++) begin
            wait_cyc(1);
            if (switch_done) begin
                n_done++;
                if (first_done == 0) first_done = c;
            end
        end
        check("sw10.done_cycle", first_done, 30);
        check("sw10.done_count", n_done, 1);

        // Invalid request then same-speed request: no sequencing
        req_valid = 1'b1; req_speed = 2'b11;
        wait_cyc(1);
        check("rej.err",  int'(switch_err), 1);
        check("rej.done", int'(switch_done), 0);
        check("rej.busy", int'(busy), 0);
        check("rej.gen",  int'(gen_speed), 2);
        req_speed = 2'b10;
        wait_cyc(1);
        req_valid = 1'b0;
        check("same.done", int'(switch_done), 1);
        check("same.err",  int'(switch_err), 0);
        check("same.busy", int'(busy), 0);
        check("same.gen",  int'(gen_speed), 2);
        wait_cyc(1);
        check("same.done_end", int'(switch_done), 0);
        check("same.busy_end", int'(busy), 0);

        // Switch to 00 with a one-cycle early drain_ack, then reset during SETTLE
        req_valid = 1'b1; req_speed = 2'b00;
        wait_cyc(1);
        req_valid = 1'b0;
        wait_cyc(2);
        drain_ack = 1'b1;
        wait_cyc(1);
        drain_ack = 1'b0;
        wait_cyc(4);
        check("sw00.c8_gen", int'(gen_speed), 2);
        wait_cyc(1);
        check("sw00.c9_gen", int'(gen_speed), 0);
        check("sw00.c9_div", int'(div_rst_n), 0);
        wait_cyc(6);
        check("sw00.c15_div",  int'(div_rst_n), 1);
        check("sw00.c15_gate", int'(clk_gate_en), 0);
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge local_clk);
        rst = 1'b1;
        check_init_seq("replay");

        // Request 01 with drain_ack never asserted
        req_valid = 1'b1; req_speed = 2'b01; drain_ack = 1'b0;
        wait_cyc(1);
        req_valid = 1'b0;
`ifdef SPEED_SW_TIMEOUT_EN
        wait_cyc(63);
        check("wd.c64_busy", int'(busy), 1);
        check("wd.c64_err",  int'(switch_err), 0);
        wait_cyc(1);
        check("wd.c65_err",  int'(switch_err), 1);
        check("wd.c65_gate", int'(clk_gate_en), 1);
        check("wd.c65_gen",  int'(gen_speed), 0);
        check("wd.c65_rdy",  int'(req_ready), 1);
        wait_cyc(1);
        check("wd.c66_err",  int'(switch_err), 0);
`else
        wait_cyc(99);
        check("nowd.c100_busy", int'(busy), 1);
        check("nowd.c100_gate", int'(clk_gate_en), 0);
        check("nowd.c100_err",  int'(switch_err), 0);
        check("nowd.c100_gen",  int'(gen_speed), 0);
        drain_ack = 1'b1;
        wait_cyc(1);
        drain_ack = 1'b0;
        check("nowd.c101_gen", int'(gen_speed), 1);
        wait_cyc(21);
        check("nowd.c122_done", int'(switch_done), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
